// File: rtl/uart_pkg.sv
// uart_pkg: encodings, FSM states and defaults shared by the UART TX and RX paths
package uart_pkg;
    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;
    localparam int DEFAULT_BAUD_DIV = 1250;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: valid/ready word intake of the UART transmitter
interface uart_tx_if #(
    parameter int DATA_BITS = 8
);
    logic                 tx_valid;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ready;
    modport master (output tx_valid, tx_data, input tx_ready);
    modport slave (input tx_valid, tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx_baudgen.sv
// baudgen_tx: end-of-bit baud tick, counter held at zero while disabled
module baudgen_tx #(
    parameter int BAUD_DIV = 1250
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam int W = $clog2(BAUD_DIV);
    logic [W-1:0] cnt;
    assign tick = en && cnt == W'(BAUD_DIV - 1);
    always_ff @(posedge clk)
        cnt <= (rst || !en || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART serial transmitter, one word per valid/ready handshake
module uart_tx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV  = DEFAULT_BAUD_DIV,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = PAR_NONE,
    parameter int STOP_BITS = 1
) (
    input  logic     clk,
    input  logic     rst,
    uart_tx_if.slave bus,
    output logic     tx_busy,
    output logic     tx
);
    localparam int IW = $clog2(DATA_BITS + 1);
    tx_state_t            state;
    logic [DATA_BITS-1:0] shreg;
    logic [IW-1:0]        idx;
    logic                 par;
    logic                 tick;

    if (BAUD_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
        $error("uart_tx: illegal parameter combination");
    end

    assign bus.tx_ready = state == IDLE;
    assign tx_busy      = state != IDLE;

    baudgen_tx #(.BAUD_DIV(BAUD_DIV)) u_baud (
        .clk  (clk),
        .rst  (rst),
        .en   (tx_busy),
        .tick (tick)
    );

    // tx is always loaded one edge ahead of the bit it carries, so the line is a flop output
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            tx    <= 1'b1;
            shreg <= '0;
            idx   <= '0;
            par   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.tx_valid) begin
                    state <= START;
                    tx    <= 1'b0;
                    shreg <= bus.tx_data;
                    idx   <= '0;
                    par   <= ^bus.tx_data ^ (PARITY == PAR_ODD);
                end
                START: if (tick) begin
                    state <= DATA;
                    tx    <= shreg[0];
                    shreg <= shreg >> 1;
                end
                DATA: if (tick) begin
                    if (idx == IW'(DATA_BITS - 1)) begin
                        idx   <= '0;
                        state <= PARITY == PAR_NONE ? STOP : uart_pkg::PARITY;
                        tx    <= PARITY == PAR_NONE ? 1'b1 : par;
                    end else begin
                        idx   <= idx + 1'b1;
                        tx    <= shreg[0];
                        shreg <= shreg >> 1;
                    end
                end
                uart_pkg::PARITY: if (tick) begin
                    state <= STOP;
                    tx    <= 1'b1;
                end
                STOP: if (tick) begin
                    idx   <= idx == IW'(STOP_BITS - 1) ? '0 : idx + 1'b1;
                    state <= idx == IW'(STOP_BITS - 1) ? IDLE : STOP;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed frame checks over four parameter sets of uart_tx
module tb_uart_tx;
    localparam int BDS[4] = '{4, 4, 4, 3};
    localparam int PARS[4] = '{0, 1, 2, 0};
    localparam int SBS[4] = '{1, 1, 1, 2};
    localparam int FRS[4] = '{40, 44, 44, 33};

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] valid, ready, busy, txl;
    logic [7:0] data [4];
    int         n_tests = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        uart_tx_if #(.DATA_BITS(8)) bus ();
        assign bus.tx_valid = valid[g];
        assign bus.tx_data  = data[g];
        assign ready[g]     = bus.tx_ready;
        uart_tx #(
            .BAUD_DIV  (BDS[g]),
            .DATA_BITS (8),
            .PARITY    (PARS[g]),
            .STOP_BITS (SBS[g])
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .bus     (bus.slave),
            .tx_busy (busy[g]),
            .tx      (txl[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // entered one cycle after the accept edge; leaves at the first idle cycle
    task automatic frame_check(input int d, input logic [7:0] w, input string tag);
        logic [11:0] bits;
        int          ok;
        bits    = '1;
        bits[0] = 1'b0;
        for (int k = 0; k < 8; k++) bits[1+k] = w[k];
        if (PARS[d] != 0) bits[9] = ^w ^ (PARS[d] == 2);
        ok = 0;
        for (int i = 0; i < FRS[d]; i++) begin
            ok += int'(txl[d] == bits[i/BDS[d]] && !ready[d] && busy[d]);
            step();
            if (i % BDS[d] == BDS[d] - 1) begin
                check($sformatf("%s bit%0d", tag, i / BDS[d]), ok, BDS[d]);
                ok = 0;
            end
        end
        check({tag, " end"}, {ready[d], busy[d], txl[d]}, 3'b101);
    endtask

    task automatic send(input int d, input logic [7:0] w, input string tag);
        data[d]  = w;
        valid[d] = 1'b1;
        step();
        valid[d] = 1'b0;
        data[d]  = ~w;
        frame_check(d, w, tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst   = 1'b1;
        valid = '0;
        for (int d = 0; d < 4; d++) data[d] = 8'h00;
        step();
        step();
        for (int d = 0; d < 4; d++)
            check($sformatf("reset dut%0d", d), {ready[d], busy[d], txl[d]}, 3'b101);
        rst = 1'b0;
        step();

        send(0, 8'h55, "8n1 55");
        send(1, 8'hA3, "even A3");
        send(2, 8'hA3, "odd A3");
        send(3, 8'hFF, "2stop FF");

        data[0]  = 8'h01;
        valid[0] = 1'b1;
        step();
        data[0] = 8'h80;
        frame_check(0, 8'h01, "b2b 01");
        step();
        valid[0] = 1'b0;
        data[0]  = 8'h00;
        frame_check(0, 8'h80, "b2b 80");

        data[0]  = 8'h3C;
        valid[0] = 1'b1;
        step();
        valid[0] = 1'b0;
        repeat (17) step();
        check("mid bit3", txl[0], 1'b1);
        rst = 1'b1;
        step();
        check("rst mid", {ready[0], busy[0], txl[0]}, 3'b101);
        rst = 1'b0;
        send(0, 8'h3C, "post rst 3C");

        data[0]  = 8'hAA;
        valid[0] = 1'b1;
        rst      = 1'b1;
        step();
        rst      = 1'b0;
        valid[0] = 1'b0;
        check("rst wins", {ready[0], busy[0], txl[0]}, 3'b101);
        step();
        check("rst wins idle", {ready[0], busy[0], txl[0]}, 3'b101);

        for (int n = 0; n < 6; n++) begin
            send(0, 8'($urandom), $sformatf("rnd8n1 %0d", n));
            send(2, 8'($urandom), $sformatf("rndodd %0d", n));
            send(3, 8'($urandom), $sformatf("rnd2stop %0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART serial transmitter, the transmit-side counterpart of the existing receive path (RX baud generator plus receiver).
- Accepts one parallel word per valid/ready handshake and serialises it onto `tx`:
  - start bit (0),
  - DATA_BITS data bits, LSB first,
  - optional parity bit,
  - 1 or 2 stop bits (1).
- Bit timing comes from an internal end-of-bit baud tick. It uses the same BAUD_DIV as the RX side, so both ends share one clock-to-baud ratio.

Parameters:
- BAUD_DIV, 1250, clk cycles per serial bit; legal range ≥ 2.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
- clk  input  1  system clock
- rst  input  1  reset: synchronous, active-high; clock clk
- tx_valid  input  1  tx_data is offered for transmission
- tx_data  input  DATA_BITS  word to send
- tx_ready  output  1  block can accept a word this cycle
- tx_busy  output  1  frame in progress
- tx  output  1  serial line, idle high

Behaviour:
- Reset values: tx=1, tx_ready=1, tx_busy=0, FSM=IDLE, baud counter=0, bit index=0, shift register=0.
- FSM states: IDLE → START → DATA → PARITY (skipped when PARITY=0) → STOP → IDLE.
- Handshake:
  - Word accepted on a rising edge where tx_valid && tx_ready.
  - tx_ready=1 only in IDLE. It is combinational from state; it does not depend on tx_valid.
  - On accept: tx_data is latched into the shift register and parity is computed from the latched value.
  - tx_data and tx_valid are ignored while busy.
- Cycle timing, with accept edge at cycle T:
  - T+1: state START, tx=0, tx_ready=0, tx_busy=1, baud counter restarts at 0.
  - Every bit holds tx for exactly BAUD_DIV cycles. The baud tick fires when counter==BAUD_DIV-1; the counter then wraps to 0 and the FSM advances.
  - Data bit k occupies cycles T+1+(1+k)*BAUD_DIV .. T+(2+k)*BAUD_DIV.
  - Parity bit value:
    - even: XOR of the data bits;
    - odd: inverted XOR of the data bits.
  - STOP lasts STOP_BITS*BAUD_DIV cycles with tx=1. The bit index counts the stop bits.
  - FRAME = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS)*BAUD_DIV.
  - At T+FRAME+1: state IDLE, tx_ready=1, tx_busy=0, tx stays 1.
- Back-to-back: if tx_valid is held, the next accept happens on the first IDLE cycle. The minimum inter-frame gap is therefore exactly 1 clk of extra idle-high beyond the stop bits.
- tx is a registered output, so there are no combinational glitches on the line.
- Counter width: $clog2(BAUD_DIV). Bit index width: $clog2(DATA_BITS+1). Counter holds at 0 in IDLE.
- Reset mid-frame: on the next edge tx=1, tx_ready=1 and the FSM goes to IDLE. A partial frame is truncated; the receiver sees a framing error, which is acceptable.
- rst and tx_valid in the same cycle: rst wins and the word is not accepted.
- Illegal parameters (PARITY>2, STOP_BITS∉{1,2}, BAUD_DIV<2): elaboration-time $error.

Decomposition:
- Shared package uart_pkg holds:
  - parity encodings PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2;
  - the FSM state enum tx_state_t {IDLE, START, DATA, PARITY, STOP};
  - default BAUD_DIV=1250, shared with the RX path.
- One sub-module is natural: baudgen_tx (parameter BAUD_DIV; ports clk, rst, en, tick).
  - Free-running counter while en=1; cleared to 0 when en=0.
  - tick=1 when counter==BAUD_DIV-1 and en=1, i.e. end-of-bit, unlike RX's mid-bit sample point.
  - uart_tx drives en from tx_busy.

Test Plan:
- Basic 8N1, BAUD_DIV=4, PARITY=0, STOP_BITS=1: send 0x55 → tx low for cycles T+1..T+4, then 1,0,1,0,1,0,1,0 each for 4 clk, stop high for 4 clk; tx_ready returns at T+41.
- Even parity, BAUD_DIV=4: send 0xA3 (four 1s) → parity bit 0. Odd parity with the same data → parity bit 1. FRAME=44 cycles.
- Two stop bits, BAUD_DIV=3: send 0xFF → stop high for 6 clk; tx_ready at T+34.
- Back-to-back with tx_valid held high, words 0x01 then 0x80 → second start falling edge occurs exactly FRAME+1 cycles after the first. tx_data changes mid-frame do not alter the first frame.
- Reset mid-frame: assert rst during data bit 3 → next cycle tx=1, tx_ready=1, tx_busy=0. A new send of 0x3C afterwards produces a clean full frame.
- Loopback: connect tx to the existing receiver with BAUD_DIV=1250, send 256 random bytes → all received bytes match, no framing errors.
